// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared VGA 640x480@60 timing constants and frame-reader types
package vga_timing_pkg;

    localparam int H_VIS   = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

    localparam int V_VIS   = 480;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 33;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    typedef enum logic {S_WAIT, S_SHOW} state_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic active;
        logic draw;
    } pix_t;

    localparam pix_t PIX_IDLE = '{hs: 1'b1, vs: 1'b1, active: 1'b0, draw: 1'b0};

    function automatic logic [9:0] clamp10(input logic [9:0] x, input logic [9:0] m);
        return (x > m) ? m : x;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel strobe, raster counters and raw sync/active decode
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_VIS,
    parameter int V_ACTIVE = V_VIS
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_en,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       hs,
    output logic       vs,
    output logic       active,
    output logic       frame_end
);

    localparam int HT       = H_ACTIVE + H_TOTAL - H_VIS;
    localparam int VT       = V_ACTIVE + V_TOTAL - V_VIS;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int VS_START = V_ACTIVE + V_FP;

    logic h_last, v_last;

    assign h_last    = h_cnt == 10'(HT - 1);
    assign v_last    = v_cnt == 10'(VT - 1);
    assign frame_end = h_last && v_last;
    assign hs        = !(h_cnt >= 10'(HS_START) && h_cnt < 10'(HS_START + H_SYNC));
    assign vs        = !(v_cnt >= 10'(VS_START) && v_cnt < 10'(VS_START + V_SYNC));
    assign active    = h_cnt < 10'(H_ACTIVE) && v_cnt < 10'(V_ACTIVE);

    // half-rate pixel strobe; raster position advances once per pixel tick
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            pix_en <= 1'b0;
            h_cnt  <= '0;
            v_cnt  <= '0;
        end else begin
            pix_en <= ~pix_en;
            if (pix_en) begin
                h_cnt <= h_last ? '0 : h_cnt + 1'b1;
                if (h_last)
                    v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end
        end

endmodule

// File: rtl/vga_frame_reader.sv
// vga_frame_reader: centres a stored grayscale image on a VGA raster and streams it out
module vga_frame_reader
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_VIS,
    parameter int V_ACTIVE = V_VIS,
    parameter int RAM_LAT  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_ready,
    input  logic [9:0]  CURRENT_WIDTH,
    input  logic [9:0]  CURRENT_HEIGHT,
    input  logic [7:0]  color_rd,
    output logic [18:0] addr_rd,
    output logic        vga_clk,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b
);

    logic       pix_en, raw_hs, raw_vs, raw_active, frame_end, frame_start;
    logic [9:0] h_cnt, v_cnt;
    logic [9:0] w_n, h_n, x0_n, y0_n;
    logic [9:0] w_q, h_q, x0_q, y0_q;
    logic [9:0] w_e, h_e, x0_e, y0_e;
    logic [10:0] x_end, y_end;
    logic       show_e, in_win;
    state_t     state;
    pix_t       pipe [0:RAM_LAT-1];
    logic [7:0] color_q;

    vga_timing_gen #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE)) u_timing (
        .clk       (clk),
        .rst       (rst),
        .pix_en    (pix_en),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .hs        (raw_hs),
        .vs        (raw_vs),
        .active    (raw_active),
        .frame_end (frame_end)
    );

    // clamped image size and centring offsets from the live inputs
    always_comb begin
        w_n  = clamp10(CURRENT_WIDTH, 10'(H_ACTIVE));
        h_n  = clamp10(CURRENT_HEIGHT, 10'(V_ACTIVE));
        x0_n = (10'(H_ACTIVE) - w_n) >> 1;
        y0_n = (10'(V_ACTIVE) - h_n) >> 1;
    end

    // the frame-start pixel itself must already see the values being latched for this frame
    assign frame_start = h_cnt == '0 && v_cnt == '0;
    assign w_e    = frame_start ? w_n : w_q;
    assign h_e    = frame_start ? h_n : h_q;
    assign x0_e   = frame_start ? x0_n : x0_q;
    assign y0_e   = frame_start ? y0_n : y0_q;
    assign show_e = frame_start ? frame_ready : state == S_SHOW;
    assign x_end  = {1'b0, x0_e} + {1'b0, w_e};
    assign y_end  = {1'b0, y0_e} + {1'b0, h_e};
    assign in_win = h_cnt >= x0_e && {1'b0, h_cnt} < x_end && v_cnt >= y0_e && {1'b0, v_cnt} < y_end;

    // frame geometry and WAIT/SHOW state, sampled once at frame start
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= S_WAIT;
            w_q   <= '0;
            h_q   <= '0;
            x0_q  <= '0;
            y0_q  <= '0;
        end else if (pix_en && frame_start) begin
            state <= frame_ready ? S_SHOW : S_WAIT;
            w_q   <= w_n;
            h_q   <= h_n;
            x0_q  <= x0_n;
            y0_q  <= y0_n;
        end

    // linear row-major read address; cleared so the new frame starts reading at 0
    always_ff @(posedge clk or posedge rst)
        if (rst)
            addr_rd <= '0;
        else if (pix_en)
            addr_rd <= frame_end ? '0 : (in_win && addr_rd != '1) ? addr_rd + 1'b1 : addr_rd;

    // delay syncs and draw flag to meet the framebuffer data; capture read data each tick
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int i = 0; i < RAM_LAT; i++)
                pipe[i] <= PIX_IDLE;
            color_q <= '0;
        end else if (pix_en) begin
            pipe[0] <= '{hs: raw_hs, vs: raw_vs, active: raw_active, draw: in_win && show_e};
            for (int i = 1; i < RAM_LAT; i++)
                pipe[i] <= pipe[i-1];
            color_q <= color_rd;
        end

    // registered VGA outputs
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
        end else if (pix_en) begin
            vga_hs      <= pipe[RAM_LAT-1].hs;
            vga_vs      <= pipe[RAM_LAT-1].vs;
            vga_blank_n <= pipe[RAM_LAT-1].active;
            vga_r       <= pipe[RAM_LAT-1].draw ? color_q : 8'h00;
            vga_g       <= pipe[RAM_LAT-1].draw ? color_q : 8'h00;
            vga_b       <= pipe[RAM_LAT-1].draw ? color_q : 8'h00;
        end

    // pixel clock is the inverse of the pixel strobe, kept as a register
    always_ff @(posedge clk or posedge rst)
        if (rst)
            vga_clk <= 1'b1;
        else
            vga_clk <= pix_en;

endmodule
